// File: rtl/mul_pkg.sv
// Shared multiplier constants, also used by the multiply FU for its result countdown.
package mul_pkg;

  localparam int MUL_WIDTH   = 32;
  localparam int MUL_LATENCY = 6;
  localparam int MUL_PWIDTH  = 2 * MUL_WIDTH;

  // Slots of the partial-product bundle carried through the first pipeline stage.
  localparam int PP_LL   = 0;
  localparam int PP_LH   = 1;
  localparam int PP_HL   = 2;
  localparam int PP_HH   = 3;
  localparam int PP_CORR = 4;
  localparam int PP_N    = 5;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mul_delay_line.sv
// Clearable shift register that pads the multiplier out to its full latency.
// DEPTH must be at least 1; the last stage is the block's output flop.
module mul_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         CLK,
  input  logic         SCLR,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH] = '{default: '0};

  // Shift one stage per clock; SCLR flushes every stage to zero.
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/multiplier_pipe.sv
// Fully pipelined WIDTH x WIDTH multiplier with exactly LATENCY clock edges of delay.
// Define MULTIPLIER_PIPE_SIGNED_EN for two's-complement operands and product.
module multiplier_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH   = MUL_WIDTH,
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic                 CLK,
  input  logic                 SCLR,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P
);

  localparam int PW  = prod_width(WIDTH);
  localparam int LO  = WIDTH / 2;
  localparam int PAD = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [PW-1:0] pp_d [PP_N];
  logic [PW-1:0] pp_s [PP_N];
  logic [PW-1:0] sum_d;

  // Split each operand in halves; the signed build adds a correction term that
  // turns the unsigned product into the two's-complement one modulo 2^PW.
  always_comb begin
    pp_d[PP_LL] = PW'(A[LO-1:0])    * PW'(B[LO-1:0]);
    pp_d[PP_LH] = PW'(A[LO-1:0])    * PW'(B[WIDTH-1:LO]);
    pp_d[PP_HL] = PW'(A[WIDTH-1:LO]) * PW'(B[LO-1:0]);
    pp_d[PP_HH] = PW'(A[WIDTH-1:LO]) * PW'(B[WIDTH-1:LO]);
`ifdef MULTIPLIER_PIPE_SIGNED_EN
    pp_d[PP_CORR] = (A[WIDTH-1] ? PW'(B) : '0) + (B[WIDTH-1] ? PW'(A) : '0);
`else
    pp_d[PP_CORR] = '0;
`endif
  end

  if (LATENCY == 1) begin : g_direct
    assign pp_s = pp_d;
  end else begin : g_staged
    logic [PW-1:0] pp_q [PP_N] = '{default: '0};

    // Partial-product register; this is where A/B are sampled.
    always_ff @(posedge CLK) begin
      if (SCLR) begin
        for (int i = 0; i < PP_N; i++) pp_q[i] <= '0;
      end else begin
        pp_q <= pp_d;
      end
    end

    assign pp_s = pp_q;
  end

  // Recombine partial products; the correction is zero in the unsigned build.
  always_comb begin
    sum_d = pp_s[PP_LL]
          + (pp_s[PP_LH] << LO)
          + (pp_s[PP_HL] << LO)
          + (pp_s[PP_HH] << (2 * LO))
          - (pp_s[PP_CORR] << WIDTH);
  end

  mul_delay_line #(
    .DEPTH (PAD),
    .W     (PW)
  ) u_out_dly (
    .CLK  (CLK),
    .SCLR (SCLR),
    .d_i  (sum_d),
    .q_o  (P)
  );

endmodule

// File: tb/tb_multiplier_pipe.sv
// Scoreboard bench: three multiplier instances (LATENCY 1, 3, 6) share one stimulus stream.
module tb_multiplier_pipe;

  localparam int W   = 32;
  localparam int NL  = 3;
  localparam int LATS [NL] = '{1, 3, 6};

  logic            CLK = 1'b0;
  logic            SCLR = 1'b0;
  logic [W-1:0]    A = '0;
  logic [W-1:0]    B = '0;
  logic [2*W-1:0]  p_s [NL];

  logic [2*W-1:0]  exp_q [NL][$];
  logic            started = 1'b0;
  int              checks = 0;
  int              errors = 0;

  always #5 CLK = ~CLK;

  multiplier_pipe #(.WIDTH(W), .LATENCY(1)) u_l1 (.CLK(CLK), .SCLR(SCLR), .A(A), .B(B), .P(p_s[0]));
  multiplier_pipe #(.WIDTH(W), .LATENCY(3)) u_l3 (.CLK(CLK), .SCLR(SCLR), .A(A), .B(B), .P(p_s[1]));
  multiplier_pipe #(.WIDTH(W), .LATENCY(6)) u_l6 (.CLK(CLK), .SCLR(SCLR), .A(A), .B(B), .P(p_s[2]));

  // Reference: plain full-width multiplication of the operands as numbers.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULTIPLIER_PIPE_SIGNED_EN
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
`else
    logic [2*W-1:0] ua;
    logic [2*W-1:0] ub;
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return ua * ub;
`endif
  endfunction

  // Drive one cycle of stimulus and record what each instance must show for it.
  task automatic drive(input logic rst, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    SCLR = rst;
    A    = a;
    B    = b;
    for (int i = 0; i < NL; i++) begin
      if (rst) begin
        for (int j = 0; j < exp_q[i].size(); j++) exp_q[i][j] = '0;
      end
      exp_q[i].push_back(rst ? {2*W{1'b0}} : ref_mul(a, b));
    end
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: every cycle each instance presents one product; compare with the queue head.
  initial begin : monitor
    logic [2*W-1:0] exp_v;
    wait (started);
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow lat=%0d: P=%h with no expected entry", LATS[i], p_s[i]);
        end else begin
          exp_v = exp_q[i].pop_front();
          if (p_s[i] !== exp_v) begin
            errors++;
            $display("FAIL product lat=%0d t=%0t: got %h expected %h", LATS[i], $time, p_s[i], exp_v);
          end
        end
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < NL; i++) begin
      for (int j = 0; j < LATS[i] - 1; j++) exp_q[i].push_back('0);
    end

    // Power-up: nothing sampled yet beyond zeros, P must read 0.
    idle(3);

    // Basic latency after a clear pulse; operands on the clear edge are ignored.
    drive(1'b1, 32'h1234_5678, 32'h9abc_def0);
    drive(1'b0, 32'd3, 32'd5);
    idle(8);

    // Full-width corners.
    drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive(1'b0, 32'h8000_0000, 32'h0000_0002);
    drive(1'b0, 32'hFFFF_FFFF, 32'h0000_0002);
    drive(1'b0, 32'h8000_0000, 32'h8000_0000);
    drive(1'b0, 32'h7FFF_FFFF, 32'h8000_0001);
    idle(8);

    // Back-to-back streaming.
    for (int i = 0; i < 20; i++) drive(1'b0, W'(i), W'(i + 1));
    idle(8);

    // Clear while products are in flight, then a held clear.
    drive(1'b0, 32'd7, 32'd9);
    drive(1'b0, 32'd11, 32'd13);
    drive(1'b1, 32'd17, 32'd19);
    drive(1'b0, 32'd2, 32'd21);
    idle(3);
    drive(1'b0, 32'd5, 32'd6);
    drive(1'b1, 32'd1, 32'd1);
    drive(1'b1, 32'd1, 32'd1);
    idle(8);

    // Random pairs with occasional clears.
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom_range(255, 0) == 0) ? 1'b1 : 1'b0, $urandom, $urandom);
    end
    idle(8);

    @(posedge CLK);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
